// File: rtl/pipa_pkg.sv
// Shared definitions for the PIPA count scheduler: axis codes, FSM states,
// net-count width and the default saturation magnitude.
package pipa_pkg;

  typedef enum logic [1:0] {
    AXIS_X = 2'd0,
    AXIS_Y = 2'd1,
    AXIS_Z = 2'd2
  } axis_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  localparam int NET_W           = 3;
  localparam int NET_MAX_DEFAULT = 3;

  // Axis reached by stepping 'step' places forward from 'last' in X->Y->Z order.
  function automatic axis_e rrAxis(axis_e last, int step);
    int idx;
    idx = (int'(last) + step) % 3;
    return axis_e'(idx[1:0]);
  endfunction

endpackage

// File: rtl/pipa_axis_net.sv
// Saturating signed net pending count for one axis; count events and the
// acknowledge step are combined into one sum before saturation.
module pipa_axis_net
  import pipa_pkg::*;
#(
  parameter int NET_MAX = NET_MAX_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    plus_i,
  input  logic                    minus_i,
  input  logic                    ackDec_i,
  input  logic                    ackInc_i,
  output logic signed [NET_W-1:0] net_o,
  output logic                    zero_o,
  output logic                    sign_o,
  output logic                    ovf_o
);

  localparam int SUM_W = NET_W + 2;
  localparam logic signed [SUM_W-1:0] SUM_ONE = SUM_W'(1);
  localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(NET_MAX);
  localparam logic signed [SUM_W-1:0] SUM_MIN = -SUM_MAX;

  logic signed [NET_W-1:0] net_q, net_d;
  logic signed [SUM_W-1:0] sum;

  always_comb begin
    sum = {{2{net_q[NET_W-1]}}, net_q};
    if (plus_i)   sum = sum + SUM_ONE;
    if (minus_i)  sum = sum - SUM_ONE;
    if (ackInc_i) sum = sum + SUM_ONE;
    if (ackDec_i) sum = sum - SUM_ONE;
    ovf_o = 1'b0;
    net_d = NET_W'(sum);
    // Anything beyond the saturation magnitude is a lost pulse.
    if (sum > SUM_MAX) begin
      net_d = NET_W'(SUM_MAX);
      ovf_o = 1'b1;
    end else if (sum < SUM_MIN) begin
      net_d = NET_W'(SUM_MIN);
      ovf_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) net_q <= '0;
    else         net_q <= net_d;
  end

  assign net_o  = net_q;
  assign zero_o = (net_q == '0);
  assign sign_o = net_q[NET_W-1];

endmodule

// File: rtl/pipa_count_scheduler.sv
// Samples the six active-low PIPA pulse lines, accumulates per-axis net counts
// and issues round-robin increment requests to the counter sequencer.
module pipa_count_scheduler
  import pipa_pkg::*;
#(
  parameter int NET_MAX = NET_MAX_DEFAULT
) (
  input  logic       CLOCK,
  input  logic       rst_,
  input  logic       PIPAXp_,
  input  logic       PIPAXm_,
  input  logic       PIPAYp_,
  input  logic       PIPAYm_,
  input  logic       PIPAZp_,
  input  logic       PIPAZm_,
  input  logic       PIPSAM,
  output logic       PIPGXp,
  output logic       PIPGXm,
  output logic       PIPGYp,
  output logic       PIPGYm,
  output logic       PIPGZp,
  output logic       PIPGZm,
  output logic       CNTREQ,
  output logic [1:0] CNTAXIS,
  output logic       CNTDIR,
  input  logic       CNTACK,
  output logic       PIPOVF,
  input  logic       CLRPIP
);

  // Bit 2*axis is the plus line, bit 2*axis+1 the minus line.
  logic [5:0] pipaIn;
  logic [5:0] pipg_q, pipg_d;
  logic [5:0] evt;
  logic       armed_q, sampled_q, sampleEn;

  state_e state_q, state_d;
  axis_e  cntAxis_q, cntAxis_d, last_q, last_d, pick;
  logic   cntDir_q, cntDir_d, ovf_q, ovf_d, ackGrant;

  logic signed [NET_W-1:0] netVal [3];
  logic [2:0] netZero, netSign, netOvf;

  assign pipaIn   = ~{PIPAZm_, PIPAZp_, PIPAYm_, PIPAYp_, PIPAXm_, PIPAXp_};
  // The strobe on the very first edge out of reset is discarded.
  assign sampleEn = PIPSAM & armed_q;
  assign pipg_d   = sampleEn ? pipaIn : pipg_q;
  assign evt      = pipg_q & {6{sampled_q}};
  assign ackGrant = (state_q == ST_REQ) & CNTACK;

  for (genvar a = 0; a < 3; a++) begin : gAxis
    logic granted;
    assign granted = ackGrant && (cntAxis_q == axis_e'(a));
    pipa_axis_net #(.NET_MAX(NET_MAX)) uNet (
      .clk_i   (CLOCK),
      .rst_ni  (rst_),
      .plus_i  (evt[2*a]),
      .minus_i (evt[2*a+1]),
      .ackDec_i(granted && !cntDir_q),
      .ackInc_i(granted && cntDir_q),
      .net_o   (netVal[a]),
      .zero_o  (netZero[a]),
      .sign_o  (netSign[a]),
      .ovf_o   (netOvf[a])
    );
  end

  always_comb begin
    state_d   = state_q;
    cntAxis_d = cntAxis_q;
    cntDir_d  = cntDir_q;
    last_d    = last_q;
    pick      = rrAxis(last_q, 1);
    // Scan lowest priority first so the highest-priority nonzero axis wins.
    for (int k = 3; k > 0; k--) begin
      if (netVal[rrAxis(last_q, k)] != '0) pick = rrAxis(last_q, k);
    end
    case (state_q)
      ST_IDLE: begin
        if (!(&netZero)) begin
          state_d   = ST_REQ;
          cntAxis_d = pick;
          cntDir_d  = netSign[pick];
        end
      end
      ST_REQ: begin
        if (CNTACK) begin
          state_d = ST_IDLE;
          last_d  = cntAxis_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ovf_d = (|netOvf) ? 1'b1 : (CLRPIP ? 1'b0 : ovf_q);
  end

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      pipg_q    <= '0;
      armed_q   <= 1'b0;
      sampled_q <= 1'b0;
      state_q   <= ST_IDLE;
      cntAxis_q <= AXIS_X;
      cntDir_q  <= 1'b0;
      last_q    <= AXIS_Z;
      ovf_q     <= 1'b0;
    end else begin
      pipg_q    <= pipg_d;
      armed_q   <= 1'b1;
      sampled_q <= sampleEn;
      state_q   <= state_d;
      cntAxis_q <= cntAxis_d;
      cntDir_q  <= cntDir_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
    end
  end

  assign {PIPGZm, PIPGZp, PIPGYm, PIPGYp, PIPGXm, PIPGXp} = pipg_q;
  assign CNTREQ  = (state_q == ST_REQ);
  assign CNTAXIS = cntAxis_q;
  assign CNTDIR  = cntDir_q;
  assign PIPOVF  = ovf_q;

endmodule

// File: tb/tb_pipa_count_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// every cycle against an integer-arithmetic reference model.
module tb_pipa_count_scheduler;

  localparam int NET_MAX = 3;

  logic       CLOCK, rst_;
  logic [5:0] pipaN;
  logic       PIPSAM, CNTACK, CLRPIP;
  logic       PIPGXp, PIPGXm, PIPGYp, PIPGYm, PIPGZp, PIPGZm;
  logic       CNTREQ, CNTDIR, PIPOVF;
  logic [1:0] CNTAXIS;

  pipa_count_scheduler #(.NET_MAX(NET_MAX)) dut (
    .CLOCK  (CLOCK),
    .rst_   (rst_),
    .PIPAXp_(pipaN[0]),
    .PIPAXm_(pipaN[1]),
    .PIPAYp_(pipaN[2]),
    .PIPAYm_(pipaN[3]),
    .PIPAZp_(pipaN[4]),
    .PIPAZm_(pipaN[5]),
    .PIPSAM (PIPSAM),
    .PIPGXp (PIPGXp),
    .PIPGXm (PIPGXm),
    .PIPGYp (PIPGYp),
    .PIPGYm (PIPGYm),
    .PIPGZp (PIPGZp),
    .PIPGZm (PIPGZm),
    .CNTREQ (CNTREQ),
    .CNTAXIS(CNTAXIS),
    .CNTDIR (CNTDIR),
    .CNTACK (CNTACK),
    .PIPOVF (PIPOVF),
    .CLRPIP (CLRPIP)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int checkCount = 0;
  int passCount  = 0;
  int cyc        = 0;

  typedef struct {int axis; int dir; int cyc;} grant_t;
  grant_t grantQ[$];

  // Reference model state: plain integers, one entry per axis.
  int         mNet[3];
  logic [5:0] mPipg;
  bit         mSamp, mArmed, mReq, mDir, mOvf;
  int         mAxis, mLast;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
  endtask

  task automatic modelReset();
    for (int a = 0; a < 3; a++) mNet[a] = 0;
    mPipg = '0; mSamp = 0; mArmed = 0; mReq = 0; mDir = 0; mOvf = 0;
    mAxis = 0; mLast = 2;
  endtask

  task automatic modelStep();
    int  nn[3];
    bit  anyOvf;
    if (!rst_) begin
      modelReset();
      return;
    end
    anyOvf = 0;
    for (int a = 0; a < 3; a++) begin
      nn[a] = mNet[a];
      if (mSamp) nn[a] = nn[a] + int'(mPipg[2*a]) - int'(mPipg[2*a+1]);
    end
    if (mReq && CNTACK) nn[mAxis] = nn[mAxis] + (mDir ? 1 : -1);
    for (int a = 0; a < 3; a++) begin
      if (nn[a] > NET_MAX) begin nn[a] = NET_MAX; anyOvf = 1; end
      else if (nn[a] < -NET_MAX) begin nn[a] = -NET_MAX; anyOvf = 1; end
    end
    if (!mReq) begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (mLast + k) % 3;
        if (mNet[c] != 0) begin
          mReq = 1; mAxis = c; mDir = (mNet[c] < 0);
          break;
        end
      end
    end else if (CNTACK) begin
      mReq = 0; mLast = mAxis;
    end
    if (anyOvf) mOvf = 1;
    else if (CLRPIP) mOvf = 0;
    mSamp = PIPSAM && mArmed;
    if (mSamp) mPipg = ~pipaN;
    mArmed = 1;
    for (int a = 0; a < 3; a++) mNet[a] = nn[a];
  endtask

  task automatic compareAll();
    int n;
    checkOutput("pipg", int'({PIPGZm, PIPGZp, PIPGYm, PIPGYp, PIPGXm, PIPGXp}), int'(mPipg));
    checkOutput("cntreq", int'(CNTREQ), int'(mReq));
    checkOutput("cntaxis", int'(CNTAXIS), mAxis);
    checkOutput("cntdir", int'(CNTDIR), int'(mDir));
    checkOutput("pipovf", int'(PIPOVF), int'(mOvf));
    for (int a = 0; a < 3; a++) begin
      n = dut.netVal[a];
      checkOutput($sformatf("net%0d", a), n, mNet[a]);
    end
    if (rst_ && CNTREQ && CNTACK)
      grantQ.push_back('{axis: int'(CNTAXIS), dir: int'(CNTDIR), cyc: cyc});
  endtask

  task automatic tick();
    @(negedge CLOCK);
    compareAll();
    modelStep();
    @(posedge CLOCK);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input bit sam, input logic [5:0] activeLines, input bit ack, input bit clr);
    PIPSAM = sam;
    pipaN  = ~activeLines;
    CNTACK = ack;
    CLRPIP = clr;
  endtask

  task automatic strobe(input logic [5:0] activeLines);
    applyStimulus(1'b1, activeLines, CNTACK, 1'b0);
    tick();
    applyStimulus(1'b0, 6'h00, CNTACK, 1'b0);
    tick();
  endtask

  // Reset, then present a strobe on the first edge after release; it must be ignored.
  task automatic doReset();
    rst_ = 1'b0;
    modelReset();
    applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
    tick();
    tick();
    rst_ = 1'b1;
    applyStimulus(1'b1, 6'h01, 1'b0, 1'b0);
    tick();
    checkOutput("first_strobe_ignored", int'(PIPGXp), 0);
    applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
    tick();
    grantQ.delete();
  endtask

  int n0;
  int expAxis[4] = '{0, 1, 2, 0};
  int expDir[4]  = '{0, 1, 0, 0};

  initial begin
    rst_ = 1'b0;
    applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
    modelReset();
    #1;
    checkOutput("reset_cntreq", int'(CNTREQ), 0);
    checkOutput("reset_ovf", int'(PIPOVF), 0);

    // Single X plus pulse, ack tied high.
    doReset();
    CNTACK = 1'b1;
    applyStimulus(1'b1, 6'h01, 1'b1, 1'b0);
    tick();
    checkOutput("s1_pipgxp", int'(PIPGXp), 1);
    applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
    repeat (8) tick();
    checkOutput("s1_grants", grantQ.size(), 1);
    if (grantQ.size() > 0) begin
      checkOutput("s1_axis", grantQ[0].axis, 0);
      checkOutput("s1_dir", grantQ[0].dir, 0);
    end
    n0 = dut.netVal[0];
    checkOutput("s1_netx", n0, 0);

    // Simultaneous Y plus and minus cancel.
    doReset();
    CNTACK = 1'b1;
    strobe(6'h0C);
    repeat (6) tick();
    checkOutput("s2_grants", grantQ.size(), 0);
    checkOutput("s2_cntreq", int'(CNTREQ), 0);

    // X+2, Y-1, Z+1 pending, then round-robin drain.
    doReset();
    strobe(6'h19);
    strobe(6'h01);
    repeat (2) tick();
    grantQ.delete();
    CNTACK = 1'b1;
    repeat (10) tick();
    checkOutput("s3_grants", grantQ.size(), 4);
    for (int i = 0; i < 4 && i < grantQ.size(); i++) begin
      checkOutput($sformatf("s3_axis%0d", i), grantQ[i].axis, expAxis[i]);
      checkOutput($sformatf("s3_dir%0d", i), grantQ[i].dir, expDir[i]);
      if (i > 0) checkOutput($sformatf("s3_gap%0d", i), grantQ[i].cyc - grantQ[i-1].cyc, 2);
    end

    // Z minus saturation and overflow clear.
    doReset();
    repeat (4) strobe(6'h20);
    n0 = dut.netVal[2];
    checkOutput("s4_netz", n0, -3);
    checkOutput("s4_ovf", int'(PIPOVF), 1);
    applyStimulus(1'b0, 6'h00, 1'b0, 1'b1);
    tick();
    CLRPIP = 1'b0;
    checkOutput("s4_ovf_clr", int'(PIPOVF), 0);

    // Direction stays latched while X net swings negative.
    doReset();
    strobe(6'h01);
    repeat (2) tick();
    checkOutput("s5_req", int'(CNTREQ), 1);
    strobe(6'h02);
    strobe(6'h02);
    tick();
    checkOutput("s5_dir", int'(CNTDIR), 0);
    CNTACK = 1'b1;
    tick();
    CNTACK = 1'b0;
    n0 = dut.netVal[0];
    checkOutput("s5_netx", n0, -2);
    repeat (3) tick();

    // Reset asserted in the middle of a request.
    doReset();
    strobe(6'h05);
    repeat (2) tick();
    checkOutput("s6_req", int'(CNTREQ), 1);
    rst_ = 1'b0;
    modelReset();
    #1;
    checkOutput("s6_req_dropped", int'(CNTREQ), 0);
    repeat (2) tick();
    rst_ = 1'b1;
    repeat (2) tick();
    for (int a = 0; a < 3; a++) begin
      n0 = dut.netVal[a];
      checkOutput($sformatf("s6_net%0d", a), n0, 0);
    end

    // Random traffic.
    doReset();
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 2) == 0), 6'($urandom), ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 99) == 0) begin
        rst_ = 1'b0;
        modelReset();
      end else begin
        rst_ = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
